// File: rtl/benes_cfg_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : benes_cfg_scheduler_if
// Brief    : Config, data-beat and switch-setting bundle of benes_cfg_scheduler.
// Revision : 1.0
// ============================================================================
interface benes_cfg_scheduler_if #(
    parameter int SIZE    = 32,
    parameter int CTX_NUM = 4
);
    localparam int LAYER_NUM  = $clog2(SIZE);
    localparam int STAGE_NUM  = 2 * LAYER_NUM - 1;
    localparam int SWITCH_NUM = SIZE / 2;
    localparam int CTX_W      = $clog2(CTX_NUM);
    localparam int STG_W      = $clog2(STAGE_NUM);

    logic                                   cfg_valid;
    logic                                   cfg_ready;
    logic [CTX_W-1:0]                       cfg_ctx;
    logic [STG_W-1:0]                       cfg_stage;
    logic [SWITCH_NUM-1:0]                  cfg_bits;
    logic                                   cfg_last;
    logic                                   in_valid;
    logic                                   in_ready;
    logic [CTX_W-1:0]                       in_ctx;
    logic [SWITCH_NUM-1:0][0:STAGE_NUM-1]   switch_set;
    logic                                   out_valid;
    logic [CTX_W-1:0]                       out_ctx;
    logic [CTX_NUM-1:0]                     ctx_ready_map;
    logic                                   err_cfg;

    modport slave (
        input  cfg_valid, cfg_ctx, cfg_stage, cfg_bits, cfg_last, in_valid, in_ctx,
        output cfg_ready, in_ready, switch_set, out_valid, out_ctx, ctx_ready_map, err_cfg
    );

    modport master (
        output cfg_valid, cfg_ctx, cfg_stage, cfg_bits, cfg_last, in_valid, in_ctx,
        input  cfg_ready, in_ready, switch_set, out_valid, out_ctx, ctx_ready_map, err_cfg
    );
endinterface
`default_nettype wire

// File: rtl/benes_cfg_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : benes_cfg_scheduler
// Brief    : Context switch-setting scheduler for a pipelined Benes network.
//            Optional BENES_CFG_STAGE_MASK_EN: promote only fully written contexts.
// Revision : 1.0
// ============================================================================
module benes_cfg_scheduler #(
    parameter int SIZE      = 32,
    parameter int STAGE_LAT = 1,
    parameter int CTX_NUM   = 4
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    benes_cfg_scheduler_if.slave  sched_if
);
    localparam int LAYER_NUM  = $clog2(SIZE);
    localparam int STAGE_NUM  = 2 * LAYER_NUM - 1;
    localparam int SWITCH_NUM = SIZE / 2;
    localparam int CTX_W      = $clog2(CTX_NUM);
    localparam int STG_W      = $clog2(STAGE_NUM);
    localparam int CNT_W      = $clog2(STAGE_NUM * STAGE_LAT + 1);
    // Last tap feeds out_valid; at STAGE_LAT=1 this is (STAGE_NUM-1)*STAGE_LAT+1.
    localparam int PIPE_D     = STAGE_NUM * STAGE_LAT;
    localparam logic [STG_W-1:0] STAGE_MAX = STG_W'(STAGE_NUM - 1);

    typedef enum logic [1:0] {
        CTX_EMPTY   = 2'd0,
        CTX_LOADING = 2'd1,
        CTX_READY   = 2'd2
    } ctx_state_t;

    ctx_state_t                     state_q    [CTX_NUM];
    ctx_state_t                     state_d    [CTX_NUM];
    logic [CNT_W-1:0]               inflight_q [CTX_NUM];
    logic [CNT_W-1:0]               inflight_d [CTX_NUM];
    logic [SWITCH_NUM-1:0]          table_q    [CTX_NUM][STAGE_NUM];
    logic [PIPE_D-1:0]              pipe_vld_q;
    logic [PIPE_D-1:0][CTX_W-1:0]   pipe_ctx_q;
    logic                           err_q;
    logic                           err_d;
`ifdef BENES_CFG_STAGE_MASK_EN
    logic [CTX_NUM-1:0][STAGE_NUM-1:0] mask_q;
    logic [CTX_NUM-1:0][STAGE_NUM-1:0] mask_d;
    logic [STAGE_NUM-1:0]              mask_new;
`endif

    logic                           cfg_fire;
    logic                           cfg_stage_ok;
    logic                           in_accept;
    logic [CTX_W-1:0]               pipe_ctx_in;
    logic [CTX_NUM-1:0]             ready_map;
    logic [SWITCH_NUM-1:0]          stage_set  [STAGE_NUM];
    logic [SWITCH_NUM-1:0][0:STAGE_NUM-1] sw_set;

    assign cfg_fire      = sched_if.cfg_valid & sched_if.cfg_ready;
    assign cfg_stage_ok  = (sched_if.cfg_stage <= STAGE_MAX);
    assign in_accept     = sched_if.in_valid & sched_if.in_ready;
    assign pipe_ctx_in   = in_accept ? sched_if.in_ctx : '0;

    assign sched_if.cfg_ready     = (inflight_q[sched_if.cfg_ctx] == '0);
    // A same-cycle write turns the context LOADING on this edge, so the beat must wait.
    assign sched_if.in_ready      = ready_map[sched_if.in_ctx] &
                                    ~(cfg_fire & cfg_stage_ok & (sched_if.cfg_ctx == sched_if.in_ctx));
    assign sched_if.ctx_ready_map = ready_map;
    assign sched_if.switch_set    = sw_set;
    assign sched_if.out_valid     = pipe_vld_q[PIPE_D-1];
    assign sched_if.out_ctx       = pipe_ctx_q[PIPE_D-1];
    assign sched_if.err_cfg       = err_q;

    always_comb begin
        ready_map = '0;
        for (int c = 0; c < CTX_NUM; c++) begin
            ready_map[c] = (state_q[c] == CTX_READY);
        end
    end

    always_comb begin
        sw_set       = '0;
        stage_set[0] = in_accept ? table_q[sched_if.in_ctx][0] : '0;
        for (int s = 1; s < STAGE_NUM; s++) begin
            stage_set[s] = pipe_vld_q[s*STAGE_LAT-1] ?
                           table_q[pipe_ctx_q[s*STAGE_LAT-1]][s] : '0;
        end
        for (int w = 0; w < SWITCH_NUM; w++) begin
            for (int s = 0; s < STAGE_NUM; s++) begin
                sw_set[w][s] = stage_set[s][w];
            end
        end
    end

    always_comb begin
        err_d = 1'b0;
        for (int c = 0; c < CTX_NUM; c++) begin
            state_d[c] = state_q[c];
        end
`ifdef BENES_CFG_STAGE_MASK_EN
        mask_d   = mask_q;
        mask_new = '0;
`endif
        if (cfg_fire) begin
            if (!cfg_stage_ok) begin
                err_d = 1'b1;
            end else begin
                state_d[sched_if.cfg_ctx] = CTX_LOADING;
`ifdef BENES_CFG_STAGE_MASK_EN
                mask_new = ((state_q[sched_if.cfg_ctx] == CTX_LOADING) ?
                            mask_q[sched_if.cfg_ctx] : '0) |
                           (STAGE_NUM'(1) << sched_if.cfg_stage);
                mask_d[sched_if.cfg_ctx] = mask_new;
                if (sched_if.cfg_last) begin
                    if (&mask_new) begin
                        state_d[sched_if.cfg_ctx] = CTX_READY;
                    end else begin
                        err_d = 1'b1;
                    end
                end
`else
                if (sched_if.cfg_last) begin
                    state_d[sched_if.cfg_ctx] = CTX_READY;
                end
`endif
            end
        end
    end

    always_comb begin
        for (int c = 0; c < CTX_NUM; c++) begin
            inflight_d[c] = inflight_q[c]
                          + CNT_W'(in_accept & (sched_if.in_ctx == CTX_W'(c)))
                          - CNT_W'(pipe_vld_q[PIPE_D-1] & (pipe_ctx_q[PIPE_D-1] == CTX_W'(c)));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int c = 0; c < CTX_NUM; c++) begin
                state_q[c]    <= CTX_EMPTY;
                inflight_q[c] <= '0;
                for (int s = 0; s < STAGE_NUM; s++) begin
                    table_q[c][s] <= '0;
                end
            end
            pipe_vld_q <= '0;
            pipe_ctx_q <= '0;
            err_q      <= 1'b0;
`ifdef BENES_CFG_STAGE_MASK_EN
            mask_q     <= '0;
`endif
        end else begin
            for (int c = 0; c < CTX_NUM; c++) begin
                state_q[c]    <= state_d[c];
                inflight_q[c] <= inflight_d[c];
            end
            if (cfg_fire && cfg_stage_ok) begin
                table_q[sched_if.cfg_ctx][sched_if.cfg_stage] <= sched_if.cfg_bits;
            end
            pipe_vld_q <= {pipe_vld_q[PIPE_D-2:0], in_accept};
            pipe_ctx_q <= {pipe_ctx_q[PIPE_D-2:0], pipe_ctx_in};
            err_q      <= err_d;
`ifdef BENES_CFG_STAGE_MASK_EN
            mask_q     <= mask_d;
`endif
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_benes_cfg_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_benes_cfg_scheduler
// Brief    : Directed self-checking bench for benes_cfg_scheduler (default build).
// Revision : 1.0
// ============================================================================
module tb_benes_cfg_scheduler;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    int   cyc;

    bit          exp_vld [0:4095];
    logic [1:0]  exp_ctx [0:4095];
    logic [15:0] exp_tbl [4][9];

    benes_cfg_scheduler_if #(.SIZE(32), .CTX_NUM(4)) bus ();

    benes_cfg_scheduler #(.SIZE(32), .STAGE_LAT(1), .CTX_NUM(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sched_if (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] get_stage(input int s);
        logic [15:0] v;
        for (int k = 0; k < 16; k++) v[k] = bus.switch_set[k][s];
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Expected network view: stage s holds the beat accepted s cycles ago.
    task automatic check_net();
        int idx;
        logic [15:0] e;
        for (int s = 0; s < 9; s++) begin
            idx = cyc - s;
            e   = '0;
            if (idx >= 0 && exp_vld[idx]) e = exp_tbl[exp_ctx[idx]][s];
            chk($sformatf("stage%0d_c%0d", s, cyc), get_stage(s), e);
        end
        idx = cyc - 9;
        chk($sformatf("out_valid_c%0d", cyc), bus.out_valid, (idx >= 0) ? exp_vld[idx] : 1'b0);
        if (idx >= 0 && exp_vld[idx]) chk($sformatf("out_ctx_c%0d", cyc), bus.out_ctx, exp_ctx[idx]);
    endtask

    task automatic net_cycle();
        @(negedge clk);
        check_net();
        tick();
    endtask

    task automatic cfg_write(input logic [1:0] c, input logic [3:0] s,
                             input logic [15:0] b, input logic l);
        bus.cfg_valid = 1'b1; bus.cfg_ctx = c; bus.cfg_stage = s;
        bus.cfg_bits  = b;    bus.cfg_last = l;
        @(negedge clk);
        chk($sformatf("cfg_ready_wr%0d_%0d", c, s), bus.cfg_ready, 1'b1);
        tick();
        bus.cfg_valid = 1'b0; bus.cfg_last = 1'b0;
        if (s < 9) exp_tbl[c][s] = b;
    endtask

    task automatic beat(input logic [1:0] c);
        bus.in_valid = 1'b1; bus.in_ctx = c;
        exp_vld[cyc] = 1'b1; exp_ctx[cyc] = c;
        #1 chk($sformatf("in_ready_beat_c%0d", cyc), bus.in_ready, 1'b1);
    endtask

    initial begin
        n_checks = 0; n_fail = 0; cyc = 0;
        for (int c = 0; c < 4; c++) for (int s = 0; s < 9; s++) exp_tbl[c][s] = '0;
        rst_n = 1'b0;
        bus.cfg_valid = 1'b0; bus.cfg_ctx = '0; bus.cfg_stage = '0; bus.cfg_bits = '0;
        bus.cfg_last  = 1'b0; bus.in_valid = 1'b1; bus.in_ctx = '0;
        tick(); tick();
        @(negedge clk);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out_ctx", bus.out_ctx, 2'd0);
        chk("rst_cfg_ready", bus.cfg_ready, 1'b1);
        chk("rst_err", bus.err_cfg, 1'b0);
        chk("rst_map", bus.ctx_ready_map, 4'b0000);
        tick();
        rst_n = 1'b1;

        // 1: empty contexts never accept and the network stays straight
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk($sformatf("t1_in_ready_%0d", i), bus.in_ready, 1'b0);
            chk($sformatf("t1_sw_zero_%0d", i), |bus.switch_set, 1'b0);
            tick();
        end
        chk("t1_map", bus.ctx_ready_map, 4'b0000);
        bus.in_valid = 1'b0;

        // 2: single-bit pattern on ctx1, one beat walks through all stages
        for (int s = 0; s < 9; s++) cfg_write(2'd1, 4'(s), 16'h0001 << s, s == 8);
        #1 chk("t2_map", bus.ctx_ready_map, 4'b0010);
        chk("t2_err", bus.err_cfg, 1'b0);
        beat(2'd1);
        net_cycle();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 11; i++) net_cycle();

        // 3: alternating ctx0 (all ones) / ctx1 back to back
        for (int s = 0; s < 9; s++) cfg_write(2'd0, 4'(s), 16'hFFFF, s == 8);
        #1 chk("t3_map", bus.ctx_ready_map, 4'b0011);
        for (int i = 0; i < 6; i++) begin
            beat(2'(i % 2));
            net_cycle();
        end
        bus.in_valid = 1'b0;
        for (int i = 0; i < 11; i++) net_cycle();

        // 4: reconfig of ctx1 is held off while its beat is in flight
        begin
            int t0;
            t0 = cyc;
            beat(2'd1);
            net_cycle();
            bus.in_valid = 1'b0;
            bus.cfg_valid = 1'b1; bus.cfg_ctx = 2'd1; bus.cfg_stage = 4'd0;
            bus.cfg_bits  = 16'hAAAA; bus.cfg_last = 1'b0;
            for (int k = 1; k <= 10; k++) begin
                @(negedge clk);
                chk($sformatf("t4_cfg_ready_%0d", k), bus.cfg_ready, (cyc <= t0 + 9) ? 1'b0 : 1'b1);
                check_net();
                tick();
            end
            bus.cfg_valid = 1'b0;
            exp_tbl[1][0] = 16'hAAAA;
        end
        bus.in_ctx = 2'd1;
        #1 chk("t4_map_loading", bus.ctx_ready_map, 4'b0001);
        chk("t4_in_ready_ctx1", bus.in_ready, 1'b0);
        bus.in_ctx = 2'd0;
        #1 chk("t4_in_ready_ctx0", bus.in_ready, 1'b1);
        // write to ctx1 and accept on ctx0 in the same cycle
        bus.cfg_valid = 1'b1; bus.cfg_ctx = 2'd1; bus.cfg_stage = 4'd1;
        bus.cfg_bits  = 16'h0F0F; bus.cfg_last = 1'b1;
        beat(2'd0);
        chk("t4_cfg_ready_other", bus.cfg_ready, 1'b1);
        net_cycle();
        bus.cfg_valid = 1'b0; bus.cfg_last = 1'b0; bus.in_valid = 1'b0;
        exp_tbl[1][1] = 16'h0F0F;
        chk("t4_map_reloaded", bus.ctx_ready_map, 4'b0011);
        for (int i = 0; i < 10; i++) net_cycle();
        // write and beat to the same context: the beat stalls
        bus.cfg_valid = 1'b1; bus.cfg_ctx = 2'd0; bus.cfg_stage = 4'd2;
        bus.cfg_bits  = 16'h00FF; bus.cfg_last = 1'b0;
        bus.in_valid  = 1'b1; bus.in_ctx = 2'd0;
        #1 chk("t4_same_ctx_stall", bus.in_ready, 1'b0);
        net_cycle();
        bus.cfg_valid = 1'b0; bus.in_valid = 1'b0;
        exp_tbl[0][2] = 16'h00FF;
        chk("t4_map_ctx0_loading", bus.ctx_ready_map, 4'b0010);
        cfg_write(2'd0, 4'd2, 16'h00FF, 1'b1);
        chk("t4_map_ctx0_ready", bus.ctx_ready_map, 4'b0011);

        // 5: out-of-range stage is accepted, flagged and has no effect
        cfg_write(2'd1, 4'd9, 16'h5555, 1'b0);
        @(negedge clk);
        chk("t5_err_pulse", bus.err_cfg, 1'b1);
        chk("t5_map_kept", bus.ctx_ready_map, 4'b0011);
        tick();
        @(negedge clk);
        chk("t5_err_clear", bus.err_cfg, 1'b0);
        tick();
        cfg_write(2'd2, 4'd15, 16'h1234, 1'b1);
        @(negedge clk);
        chk("t5_err_pulse2", bus.err_cfg, 1'b1);
        chk("t5_ctx2_not_ready", bus.ctx_ready_map, 4'b0011);
        tick();
        beat(2'd1);
        net_cycle();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 11; i++) net_cycle();

        // 6: reset with five beats in flight flushes everything
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1; bus.in_ctx = 2'd0;
            tick();
        end
        bus.in_valid = 1'b0; bus.cfg_ctx = 2'd0; rst_n = 1'b0;
        @(negedge clk);
        chk("t6_busy_before_rst", bus.cfg_ready, 1'b0);
        tick();
        @(negedge clk);
        chk("t6_out_valid", bus.out_valid, 1'b0);
        chk("t6_sw_zero", |bus.switch_set, 1'b0);
        chk("t6_map", bus.ctx_ready_map, 4'b0000);
        chk("t6_err", bus.err_cfg, 1'b0);
        for (int c = 0; c < 4; c++) begin
            bus.cfg_ctx = 2'(c);
            #1 chk($sformatf("t6_cnt_zero_%0d", c), bus.cfg_ready, 1'b1);
        end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            chk($sformatf("t6_no_out_%0d", i), bus.out_valid, 1'b0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
